// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: access size encodings, FSM states,
// and the alignment helper used when DMEM_ARB_ALIGN_CHK_EN is defined.
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_e;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic size_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last time.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_win,
    output logic [NUM_REQ-1:0] win_oh
);

    // One-hot winner selection.
    always_comb begin
        win_oh = 2'b00;
        case (req)
            2'b01:   win_oh = 2'b01;
            2'b10:   win_oh = 2'b10;
            2'b11:   win_oh = last_win ? 2'b01 : 2'b10;
            default: win_oh = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU MEM stage and loader/debug port).
// Optional alignment checking is enabled with the DMEM_ARB_ALIGN_CHK_EN macro.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            rw,
    input  logic [3:0]            size,
    input  logic [1:0]            se,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  m_e,
    output logic                  m_rw,
    output logic [1:0]            m_size,
    output logic                  m_se,
    output logic [ADDR_W-1:0]     m_a,
    output logic [DATA_W-1:0]     m_di,
    input  logic [DATA_W-1:0]     m_do
);

    arb_state_e          state_r;
    arb_state_e          state_s;
    logic                last_r;
    logic                win_r;

    logic [1:0]          win_oh_s;
    logic                win_idx_s;
    logic                sel_rw_s;
    logic [1:0]          sel_size_s;
    logic                sel_se_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_bad_s;

    logic                cmd_rw_r;
    logic [1:0]          cmd_size_r;
    logic                cmd_se_r;
    logic [ADDR_W-1:0]   cmd_addr_r;
    logic [DATA_W-1:0]   cmd_wdata_r;
    logic                cmd_bad_r;

    logic [1:0]          gnt_r;
    logic [1:0]          rvalid_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                err_r;
    logic                m_e_r;
    logic                m_rw_r;
    logic [1:0]          m_size_r;
    logic                m_se_r;
    logic [ADDR_W-1:0]   m_a_r;
    logic [DATA_W-1:0]   m_di_r;

    dmem_rr_pick u_pick (
        .req      (req),
        .last_win (last_r),
        .win_oh   (win_oh_s)
    );

    // Route the winning requester's command fields and classify it.
    always_comb begin
        win_idx_s = win_oh_s[1];
        if (win_idx_s) begin
            sel_rw_s    = rw[1];
            sel_size_s  = size[3:2];
            sel_se_s    = se[1];
            sel_addr_s  = addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = wdata[2*DATA_W-1:DATA_W];
        end else begin
            sel_rw_s    = rw[0];
            sel_size_s  = size[1:0];
            sel_se_s    = se[0];
            sel_addr_s  = addr[ADDR_W-1:0];
            sel_wdata_s = wdata[DATA_W-1:0];
        end
`ifdef DMEM_ARB_ALIGN_CHK_EN
        sel_bad_s = (sel_size_s == SZ_ILLEGAL) || size_misaligned(sel_size_s, sel_addr_s[1:0]);
`else
        sel_bad_s = (sel_size_s == SZ_ILLEGAL);
`endif
    end

    // Next-state logic: fixed IDLE -> ACCESS -> RESP loop once a request is seen.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch and last-winner pointer; requesters may change fields after grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r       <= 1'b0;
            last_r      <= 1'b1;
            cmd_rw_r    <= 1'b0;
            cmd_size_r  <= SZ_BYTE;
            cmd_se_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            cmd_bad_r   <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && (req != 2'b00)) begin
                win_r       <= win_idx_s;
                cmd_rw_r    <= sel_rw_s;
                cmd_size_r  <= sel_size_s;
                cmd_se_r    <= sel_se_s;
                cmd_addr_r  <= sel_addr_s;
                cmd_wdata_r <= sel_wdata_s;
                cmd_bad_r   <= sel_bad_s;
            end
            if (state_r == ST_RESP) begin
                last_r <= win_r;
            end
        end
    end

    // Registered outputs: each state's effect appears on the pins in the following
    // cycle, so gnt, the memory strobe and rvalid land on three consecutive cycles
    // and the strobe is never high in any other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r    <= 2'b00;
            rvalid_r <= 2'b00;
            rdata_r  <= {DATA_W{1'b0}};
            err_r    <= 1'b0;
            m_e_r    <= 1'b0;
            m_rw_r   <= 1'b0;
            m_size_r <= SZ_BYTE;
            m_se_r   <= 1'b0;
            m_a_r    <= {ADDR_W{1'b0}};
            m_di_r   <= {DATA_W{1'b0}};
        end else begin
            gnt_r <= (state_r == ST_IDLE) ? win_oh_s : 2'b00;

            if ((state_r == ST_ACCESS) && !cmd_bad_r) begin
                m_e_r    <= 1'b1;
                m_rw_r   <= cmd_rw_r;
                m_size_r <= cmd_size_r;
                m_se_r   <= cmd_se_r;
                m_a_r    <= cmd_addr_r;
                m_di_r   <= cmd_wdata_r;
            end else begin
                m_e_r    <= 1'b0;
                m_rw_r   <= 1'b0;
                m_size_r <= SZ_BYTE;
                m_se_r   <= 1'b0;
                m_a_r    <= {ADDR_W{1'b0}};
                m_di_r   <= {DATA_W{1'b0}};
            end

            // The strobe cycle ends here, so m_do still reflects the latched command.
            if (state_r == ST_RESP) begin
                rvalid_r <= win_r ? 2'b10 : 2'b01;
                rdata_r  <= (!cmd_bad_r && !cmd_rw_r) ? m_do : {DATA_W{1'b0}};
                err_r    <= cmd_bad_r;
            end else begin
                rvalid_r <= 2'b00;
                rdata_r  <= {DATA_W{1'b0}};
                err_r    <= 1'b0;
            end
        end
    end

    assign gnt    = gnt_r;
    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign err    = err_r;
    assign m_e    = m_e_r;
    assign m_rw   = m_rw_r;
    assign m_size = m_size_r;
    assign m_se   = m_se_r;
    assign m_a    = m_a_r;
    assign m_di   = m_di_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian byte memory model.
// Expected values follow DMEM_ARB_ALIGN_CHK_EN when it is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0]      rw;
    logic [3:0]      size;
    logic [1:0]      se;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            m_e;
    logic            m_rw;
    logic [1:0]      m_size;
    logic            m_se;
    logic [AW-1:0]   m_a;
    logic [DW-1:0]   m_di;
    logic [DW-1:0]   m_do;

    logic [7:0]      mem [0:511];
    int              total_cnt = 0;
    int              bad_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .size(size), .se(se),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .err(err), .m_e(m_e), .m_rw(m_rw), .m_size(m_size), .m_se(m_se),
        .m_a(m_a), .m_di(m_di), .m_do(m_do)
    );

    function automatic int ix(input logic [AW-1:0] a, input int k);
        return (int'(a) + k) % 512;
    endfunction

    // Memory read path: combinational, big-endian, extends bytes/halfwords.
    always_comb begin
        m_do = 32'h0;
        case (m_size)
            SZ_BYTE: m_do = m_se ? {{24{mem[ix(m_a,0)][7]}}, mem[ix(m_a,0)]}
                                 : {24'h0, mem[ix(m_a,0)]};
            SZ_HALF: m_do = m_se ? {{16{mem[ix(m_a,0)][7]}}, mem[ix(m_a,0)], mem[ix(m_a,1)]}
                                 : {16'h0, mem[ix(m_a,0)], mem[ix(m_a,1)]};
            SZ_WORD: m_do = {mem[ix(m_a,0)], mem[ix(m_a,1)], mem[ix(m_a,2)], mem[ix(m_a,3)]};
            default: m_do = 32'h0;
        endcase
    end

    // Memory write path.
    always @(posedge clk) begin
        if (m_e && m_rw) begin
            case (m_size)
                SZ_BYTE: mem[ix(m_a,0)] <= m_di[7:0];
                SZ_HALF: begin
                    mem[ix(m_a,0)] <= m_di[15:8];
                    mem[ix(m_a,1)] <= m_di[7:0];
                end
                SZ_WORD: begin
                    mem[ix(m_a,0)] <= m_di[31:24];
                    mem[ix(m_a,1)] <= m_di[23:16];
                    mem[ix(m_a,2)] <= m_di[15:8];
                    mem[ix(m_a,3)] <= m_di[7:0];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic w, input logic [1:0] sz, input logic s,
                           input logic [AW-1:0] a, input logic [31:0] d);
        req[r]            = 1'b1;
        rw[r]             = w;
        size[r*2 +: 2]    = sz;
        se[r]             = s;
        addr[r*AW +: AW]  = a;
        wdata[r*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete transaction, starting and ending on a falling edge.
    task automatic xact(input string tag, input int r, input logic w, input logic [1:0] sz,
                        input logic s, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input logic exp_me);
        set_req(r, w, sz, s, a, d);
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(gnt), 32'(1 << r));
        req[r]            = 1'b0;
        addr[r*AW +: AW]  = ~a;
        wdata[r*DW +: DW] = ~d;
        size[r*2 +: 2]    = SZ_ILLEGAL;
        @(negedge clk);
        chk({tag, ".m_e"}, 32'(m_e), 32'(exp_me));
        if (exp_me) chk({tag, ".m_a"}, 32'(m_a), 32'(a));
        @(negedge clk);
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(1 << r));
        chk({tag, ".rdata"}, rdata, exp_rd);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        chk({tag, ".rvalid_off"}, 32'(rvalid), 32'h0);
    endtask

    logic al_err;
    logic al_me;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        mem[2]  <= 8'hA1; mem[3]  <= 8'hB2; mem[4]  <= 8'hC3; mem[5]  <= 8'hD4;
        mem[8]  <= 8'h12; mem[9]  <= 8'h34; mem[10] <= 8'h56; mem[11] <= 8'h78;
        rst_n = 1'b0;
        req = 2'b11; rw = 2'b00; size = 4'b1010; se = 2'b00;
        addr = '0; wdata = '0;

        // Reset state, with requests pending that must be ignored.
        repeat (2) @(negedge clk);
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.rvalid", 32'(rvalid), 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.m_e", 32'(m_e), 32'h0);
        chk("rst.m_rw", 32'(m_rw), 32'h0);
        chk("rst.m_a", 32'(m_a), 32'h0);
        chk("rst.m_di", m_di, 32'h0);
        req = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        xact("rd_word", 0, 1'b0, SZ_WORD, 1'b0, 9'h008, 32'h0, 32'h12345678, 1'b0, 1'b1);
        xact("wr_word", 1, 1'b1, SZ_WORD, 1'b0, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        xact("rd_byte_se", 0, 1'b0, SZ_BYTE, 1'b1, 9'h010, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b1);
        xact("rd_byte_ze", 0, 1'b0, SZ_BYTE, 1'b0, 9'h011, 32'h0, 32'h000000AD, 1'b0, 1'b1);
        xact("rd_half_se", 1, 1'b0, SZ_HALF, 1'b1, 9'h012, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1);
        xact("rd_half_ze", 0, 1'b0, SZ_HALF, 1'b0, 9'h012, 32'h0, 32'h0000BEEF, 1'b0, 1'b1);

`ifdef DMEM_ARB_ALIGN_CHK_EN
        al_err = 1'b1; al_me = 1'b0;
        xact("mis_word", 0, 1'b0, SZ_WORD, 1'b0, 9'h002, 32'h0, 32'h0, al_err, al_me);
        xact("mis_half", 1, 1'b0, SZ_HALF, 1'b0, 9'h009, 32'h0, 32'h0, al_err, al_me);
`else
        al_err = 1'b0; al_me = 1'b1;
        xact("mis_word", 0, 1'b0, SZ_WORD, 1'b0, 9'h002, 32'h0, 32'hA1B2C3D4, al_err, al_me);
        xact("mis_half", 1, 1'b0, SZ_HALF, 1'b0, 9'h009, 32'h0, 32'h00003456, al_err, al_me);
`endif

        xact("illegal_wr", 1, 1'b1, SZ_ILLEGAL, 1'b0, 9'h008, 32'h11111111, 32'h0, 1'b1, 1'b0);
        xact("after_illegal", 0, 1'b0, SZ_WORD, 1'b0, 9'h008, 32'h0, 32'h12345678, 1'b0, 1'b1);

        // Contention from a fresh reset: grants alternate 0,1,0,1 every 3 cycles.
        do_reset();
        set_req(0, 1'b0, SZ_WORD, 1'b0, 9'h008, 32'h0);
        set_req(1, 1'b0, SZ_WORD, 1'b0, 9'h010, 32'h0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            logic [1:0]  exp_g;
            logic [1:0]  exp_v;
            logic [31:0] exp_d;
            @(negedge clk);
            exp_g = (cyc % 3 == 1) ? (((cyc / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_v = (cyc % 3 == 0) ? ((((cyc - 2) / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_d = (exp_v == 2'b01) ? 32'h12345678 : ((exp_v == 2'b10) ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("cont.gnt.c%0d", cyc), 32'(gnt), 32'(exp_g));
            chk($sformatf("cont.rvalid.c%0d", cyc), 32'(rvalid), 32'(exp_v));
            if (exp_v != 2'b00) chk($sformatf("cont.rdata.c%0d", cyc), rdata, exp_d);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Reset during the memory strobe aborts a write.
        set_req(1, 1'b1, SZ_WORD, 1'b0, 9'h020, 32'h55AA55AA);
        @(negedge clk);
        chk("abort.gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        @(negedge clk);
        chk("abort.m_e_pre", 32'(m_e), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort.m_e", 32'(m_e), 32'h0);
        chk("abort.m_rw", 32'(m_rw), 32'h0);
        @(negedge clk);
        chk("abort.rvalid_rst", 32'(rvalid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.rvalid_rel", 32'(rvalid), 32'h0);
        @(negedge clk);
        chk("abort.rvalid_rel2", 32'(rvalid), 32'h0);
        chk("abort.mem", {mem[32], mem[33], mem[34], mem[35]}, 32'h0);
        xact("post_abort", 0, 1'b0, SZ_WORD, 1'b0, 9'h020, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width of the data memory.
REQ-002 Parameter DATA_W, default 32, data width of the data memory.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  2  per-requester access request; bit 0 is the CPU MEM stage, bit 1 is the loader/debug port.
REQ-006 rw  input  2  per-requester direction; 0 = read, 1 = write.
REQ-007 size  input  4  per-requester size, 2 bits each: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 se  input  2  per-requester sign-extend flag for byte and halfword reads.
REQ-009 addr  input  2*ADDR_W  per-requester byte address, requester i at [i*ADDR_W +: ADDR_W].
REQ-010 wdata  input  2*DATA_W  per-requester write data.
REQ-011 gnt  output  2  one-cycle pulse when that requester's command is latched.
REQ-012 rvalid  output  2  one-cycle completion pulse for reads and writes.
REQ-013 rdata  output  DATA_W  read data, valid only while some rvalid bit is high.
REQ-014 err  output  1  error flag, qualified by rvalid.
REQ-015 m_e, m_rw, m_size[1:0], m_se, m_a[ADDR_W-1:0], m_di[DATA_W-1:0]  outputs  memory enable, direction, size, sign-extend, address and write data.
REQ-016 m_do  input  DATA_W  memory read data, combinational from the m_* outputs.

Function
REQ-017 FSM states are IDLE, ACCESS and RESP; the FSM always runs IDLE -> ACCESS -> RESP -> IDLE.
REQ-018 IDLE: with no req bit set, remain in IDLE; otherwise pick a winner, latch its rw/size/se/addr/wdata, pulse gnt[winner] and go to ACCESS on the same edge.
REQ-019 Arbitration: a single requesting bit wins; if both request, the requester that did not win last wins; the last-winner pointer updates in RESP.
REQ-020 ACCESS: drive m_e=1 and the latched fields on m_* for exactly one cycle; for a read, register m_do into rdata at the end of that cycle.
REQ-021 Outside ACCESS, hold m_e=0 and m_rw=0, because the memory writes combinationally while E and R_W are both high.
REQ-022 RESP: pulse rvalid[winner] for one cycle; rdata holds the captured value for reads and is 0 for writes.
REQ-023 Latency: gnt appears one cycle after req is sampled, and rvalid two cycles after gnt; peak throughput is one access per 3 cycles.
REQ-024 A requester holds its request fields until gnt and may drop or change them after gnt without affecting the transaction in flight.
REQ-025 A req still asserted in the RESP cycle counts as a new request in the following IDLE cycle.
REQ-026 size=11 is illegal: m_e stays 0 in ACCESS, the response carries err=1 and rdata=0, and this holds regardless of the configuration macro.

Reset
REQ-027 While rst_n=0: FSM in IDLE; gnt, rvalid, rdata, err and all m_* outputs are 0; the last-winner pointer is 1, so requester 0 wins the first tie.
REQ-028 Reset asserted in ACCESS or RESP aborts the transaction: no rvalid is issued and m_e drops immediately.

Configuration
REQ-029 With DMEM_ARB_ALIGN_CHK_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=00 is not sent to memory (m_e=0) and completes with err=1 and rdata=0.
REQ-030 Without DMEM_ARB_ALIGN_CHK_EN, misaligned accesses go to memory unchanged and err is set only for size=11.

Structure
REQ-031 Package dmem_arb_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL) and the FSM state enum.
REQ-032 A sub-module dmem_rr_pick SHALL implement the 2-way round-robin pick (req, last pointer -> one-hot winner).

Verification
REQ-033 Single read: req=01, size=10, addr=0x008 with the memory word at 0x008 = 0x12345678 -> gnt=01 at cycle 1, m_e=1 at cycle 2, rvalid=01 with rdata=0x12345678 and err=0 at cycle 3.
REQ-034 Contention: req=11 held continuously after reset -> grant order 0,1,0,1 with gnt pulses exactly 3 cycles apart.
REQ-035 Write then read-back: requester 1 writes word 0xDEADBEEF at 0x010, then requester 0 reads byte 0x010 with se=1 -> rdata=0xFFFFFFDE.
REQ-036 Alignment: word access at addr=0x002 -> with the macro, m_e stays 0 and err=1 with rvalid; without the macro, m_e=1 and err=0.
REQ-037 Illegal size and reset: size=11 -> err=1 and no m_e pulse; rst_n asserted during ACCESS -> m_e=0 at once, no rvalid, and IDLE after release.
